// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle logic ALU: opcodes, default widths
// and the FSM state encoding.
package alu_pkg;

    localparam logic [1:0] OP_AND     = 2'b00;
    localparam logic [1:0] OP_OR      = 2'b01;
    localparam logic [1:0] OP_XOR     = 2'b10;
    localparam logic [1:0] OP_ILLEGAL = 2'b11;

    localparam int unsigned DATA_W_DEF  = 64;
    localparam int unsigned SLICE_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/logic_slice_16.sv
// Combinational AND/OR/XOR slice unit; yields zero for the illegal opcode
// and flags whether the slice result is nonzero.
module logic_slice_16
    import alu_pkg::*;
#(
    parameter int unsigned W = SLICE_W_DEF
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [1:0]   op,
    output logic [W-1:0] y,
    output logic         nz
);

    logic [W-1:0] and_v;
    logic [W-1:0] or_v;
    logic [W-1:0] xor_v;

    assign and_v = a & b;
    assign or_v  = a | b;
    assign xor_v = a ^ b;

    always_comb begin
        y = '0;
        case (op)
            OP_AND:  y = and_v;
            OP_OR:   y = or_v;
            OP_XOR:  y = xor_v;
            default: y = '0;
        endcase
    end

    assign nz = |y;

endmodule

// File: rtl/alu_logic_multicycle.sv
// Multi-cycle logic unit: one SLICE_W-bit slice per cycle through a shared
// slice unit, with a valid/ready request and response handshake.
module alu_logic_multicycle
    import alu_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned SLICE_W = SLICE_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [1:0]        in_op,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic              out_zero,
    output logic              out_err
);

    localparam int unsigned NSLICE = DATA_W / SLICE_W;
    localparam int unsigned CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSLICE - 1);

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic [1:0]          op_q, op_d;
    logic [DATA_W-1:0]   res_q, res_d;
    logic                nz_q, nz_d;

    logic [SLICE_W-1:0]  slice_a;
    logic [SLICE_W-1:0]  slice_b;
    logic [SLICE_W-1:0]  slice_y;
    logic                slice_nz;

    assign slice_a = a_q[cnt_q*SLICE_W +: SLICE_W];
    assign slice_b = b_q[cnt_q*SLICE_W +: SLICE_W];

    logic_slice_16 #(.W(SLICE_W)) u_slice (
        .a  (slice_a),
        .b  (slice_b),
        .op (op_q),
        .y  (slice_y),
        .nz (slice_nz)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        nz_d    = nz_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    op_d    = in_op;
                    res_d   = '0;
                    nz_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                res_d[cnt_q*SLICE_W +: SLICE_W] = slice_y;
                nz_d = nz_q | slice_nz;
                // Terminal count checked explicitly so non-power-of-two NSLICE works.
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            nz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            nz_q    <= nz_d;
        end
    end

    // in_ready is masked by rst so it stays low for the whole reset pulse.
    assign in_ready   = (state_q == ST_IDLE) && !rst;
    assign out_valid  = (state_q == ST_DONE);
    assign out_result = res_q;
    assign out_zero   = (state_q == ST_DONE) && !nz_q;
    assign out_err    = (state_q == ST_DONE) && (op_q == OP_ILLEGAL);

endmodule

// File: tb/tb_alu_logic_multicycle.sv
// Scoreboard bench for alu_logic_multicycle: directed vectors push expected
// responses; a monitor pops and compares on every response handshake.
module tb_alu_logic_multicycle;
    import alu_pkg::*;

    typedef struct packed {
        logic [63:0] r;
        logic        z;
        logic        e;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_a = '0;
    logic [63:0] in_b = '0;
    logic [1:0]  in_op = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] out_result;
    logic        out_zero;
    logic        out_err;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];
    exp_t mon_e;

    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    alu_logic_multicycle #(.DATA_W(64), .SLICE_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_zero   (out_zero),
        .out_err    (out_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_response: got result %h with no expected entry", out_result);
            end else begin
                mon_e = sb.pop_front();
                chk("sb_result", out_result, mon_e.r);
                chk("sb_zero", 64'(out_zero), 64'(mon_e.z));
                chk("sb_err", 64'(out_err), 64'(mon_e.e));
            end
        end
    end

    // Drives one request through its accept edge; returns #1 after that edge.
    task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic [1:0] op,
                         input exp_t e, input bit expect_resp);
        int n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ready_before_issue", 64'(in_ready), 64'd1);
        in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
        if (expect_resp) sb.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Counts cycles from the request cycle until out_valid is seen.
    task automatic measure_latency(input string name);
        int lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk(name, 64'(lat), 64'd5);
    endtask

    task automatic run_txn(input string name, input logic [63:0] a, input logic [63:0] b,
                           input logic [1:0] op, input logic [63:0] r, input logic z, input logic e);
        exp_t x;
        x.r = r; x.z = z; x.e = e;
        issue(a, b, op, x, 1'b1);
        measure_latency(name);
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t bp;
        int n;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_result", out_result, 64'd0);
        chk("rst_zero", 64'(out_zero), 64'd0);
        chk("rst_err", 64'(out_err), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1 chk("ready_after_rst", 64'(in_ready), 64'd1);

        run_txn("lat_and", 64'hFFFF_0000_FFFF_0000, 64'h0F0F_0F0F_0F0F_0F0F, OP_AND,
                64'h0F0F_0000_0F0F_0000, 1'b0, 1'b0);
        run_txn("lat_xor", 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, OP_XOR,
                64'h0, 1'b1, 1'b0);
        run_txn("lat_or_top", 64'h8000_0000_0000_0000, 64'h0, OP_OR,
                64'h8000_0000_0000_0000, 1'b0, 1'b0);
        run_txn("lat_or_bot", 64'h0000_0000_0000_0001, 64'h0, OP_OR,
                64'h0000_0000_0000_0001, 1'b0, 1'b0);

        // Backpressure: response held while inputs churn.
        out_ready = 1'b0;
        bp.r = 64'hF00F_F00F_0FF0_0FF0; bp.z = 1'b0; bp.e = 1'b0;
        issue(64'hFF00_FF00_00FF_00FF, 64'h0F0F_0F0F_0F0F_0F0F, OP_XOR, bp, 1'b1);
        measure_latency("lat_bp");
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            in_a = ~in_a;
            in_b = in_b + 64'd3;
            in_op = 2'(i);
            @(posedge clk); #1;
            chk("bp_valid", 64'(out_valid), 64'd1);
            chk("bp_result", out_result, bp.r);
            chk("bp_zero", 64'(out_zero), 64'd0);
            chk("bp_err", 64'(out_err), 64'd0);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_ready", 64'(in_ready), 64'd1);
        chk("bp_release_valid", 64'(out_valid), 64'd0);

        run_txn("lat_illegal", ONES, ONES, OP_ILLEGAL, 64'h0, 1'b1, 1'b1);

        // Reset while slice 2 is being computed; no response may follow.
        issue(ONES, ONES, OP_AND, bp, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("partial_result", out_result, 64'h0000_0000_FFFF_FFFF);
        rst = 1'b1;
        #1;
        chk("midrst_valid", 64'(out_valid), 64'd0);
        chk("midrst_result", out_result, 64'd0);
        chk("midrst_ready", 64'(in_ready), 64'd0);
        chk("midrst_zero", 64'(out_zero), 64'd0);
        chk("midrst_err", 64'(out_err), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1 chk("ready_after_midrst", 64'(in_ready), 64'd1);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("no_spurious_valid", 64'(out_valid), 64'd0);
        end

        run_txn("lat_and_ones", ONES, ONES, OP_AND, ONES, 1'b0, 1'b0);

        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
